// File: rtl/mv_pattern_bands.sv
// Colour-band test pattern generator with a 2-clock pipeline from the timing inputs to rgb.
// Optional per-frame band scrolling is compiled in with the macro MV_PATTERN_SCROLL_EN.
module mv_pattern_bands #(
    parameter int BAND_NUM   = 8,
    parameter int BAND_SHIFT = 8,
    parameter int COLOR_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_hs,
    input  logic               timing_vs,
    input  logic               timing_de,
    input  logic [11:0]        timing_x,
    input  logic [11:0]        timing_y,
    input  logic               mode,
    input  logic               scroll_en,
    input  logic [7:0]         scroll_step,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COLOR_W-1:0] rgb_r,
    output logic [COLOR_W-1:0] rgb_g,
    output logic [COLOR_W-1:0] rgb_b
);
    localparam int POS_W = $clog2(BAND_NUM) + BAND_SHIFT;
    localparam int OFS_W = BAND_SHIFT + 4;

    logic               r_vs_prev;
    logic               r_active_mode;
    logic               w_frame_start;
    logic [OFS_W-1:0]   w_offset;
    logic [11:0]        w_coord;
    logic [15:0]        w_sum;
    logic [POS_W-1:0]   w_pos;
    logic [3:0]         w_band;
    logic [BAND_SHIFT-1:0] w_ramp;
    logic [COLOR_W-1:0] w_g;
    logic               w_unused_bits;

    logic               r_hs1, r_vs1, r_de1;
    logic [2:0]         r_band1;
    logic [COLOR_W-1:0] r_g1;
    logic [COLOR_W-1:0] w_r_nxt, w_g_nxt, w_b_nxt;

    assign w_frame_start = timing_vs & ~r_vs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_prev     <= 1'b0;
            r_active_mode <= 1'b0;
        end else begin
            r_vs_prev <= timing_vs;
            if (w_frame_start)
                r_active_mode <= mode;
        end
    end

`ifdef MV_PATTERN_SCROLL_EN
    logic [OFS_W-1:0] r_offset;
    logic [15:0]      w_ofs_sum;
    logic             w_unused_ofs;

    // SPAN is a power of two, so the modulo is just the low POS_W bits.
    assign w_ofs_sum    = 16'(r_offset) + {8'd0, scroll_step};
    assign w_unused_ofs = ^w_ofs_sum[15:POS_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_offset <= '0;
        else if (w_frame_start && scroll_en)
            r_offset <= OFS_W'(w_ofs_sum[POS_W-1:0]);
    end

    assign w_offset = r_offset;
`else
    logic w_unused_scroll;
    assign w_unused_scroll = ^{scroll_en, scroll_step};
    assign w_offset        = '0;
`endif

    assign w_coord       = r_active_mode ? timing_x : timing_y;
    assign w_sum         = {4'd0, w_coord} + 16'(w_offset);
    assign w_pos         = w_sum[POS_W-1:0];
    assign w_band        = 4'(w_pos >> BAND_SHIFT);
    assign w_ramp        = w_pos[BAND_SHIFT-1:0];
    assign w_unused_bits = ^{w_sum[15:POS_W], w_band[3]};

    generate
        if (BAND_SHIFT >= COLOR_W) begin : g_ramp_top
            assign w_g = w_ramp[BAND_SHIFT-1 -: COLOR_W];
        end else begin : g_ramp_shl
            assign w_g = {w_ramp, {(COLOR_W-BAND_SHIFT){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_de1   <= 1'b0;
            r_band1 <= '0;
            r_g1    <= '0;
        end else begin
            r_hs1   <= timing_hs;
            r_vs1   <= timing_vs;
            r_de1   <= timing_de;
            r_band1 <= w_band[2:0];
            r_g1    <= w_g;
        end
    end

    always_comb begin
        w_r_nxt = '0;
        w_g_nxt = '0;
        w_b_nxt = '0;
        case (r_band1)
            3'd0: begin w_r_nxt = '1;   w_g_nxt = r_g1; w_b_nxt = r_g1; end
            3'd1: begin w_r_nxt = r_g1; w_g_nxt = '1;   w_b_nxt = r_g1; end
            3'd2: begin w_r_nxt = r_g1; w_g_nxt = r_g1; w_b_nxt = '1;   end
            3'd3: begin w_r_nxt = '1;   w_g_nxt = r_g1; w_b_nxt = '1;   end
            3'd4: begin w_r_nxt = '0;   w_g_nxt = '0;   w_b_nxt = r_g1; end
            3'd5: begin w_r_nxt = '1;   w_g_nxt = '1;   w_b_nxt = r_g1; end
            3'd6: begin w_r_nxt = r_g1; w_g_nxt = r_g1; w_b_nxt = r_g1; end
            default: begin w_r_nxt = '0; w_g_nxt = '0;  w_b_nxt = '0;   end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs    <= 1'b0;
            vs    <= 1'b0;
            de    <= 1'b0;
            rgb_r <= '0;
            rgb_g <= '0;
            rgb_b <= '0;
        end else begin
            hs    <= r_hs1;
            vs    <= r_vs1;
            de    <= r_de1;
            rgb_r <= r_de1 ? w_r_nxt : '0;
            rgb_g <= r_de1 ? w_g_nxt : '0;
            rgb_b <= r_de1 ? w_b_nxt : '0;
        end
    end
endmodule

// File: tb/tb_mv_pattern_bands.sv
// Directed bench for mv_pattern_bands: default build plus a BAND_NUM=4/BAND_SHIFT=5 instance.
// Scroll checks follow MV_PATTERN_SCROLL_EN so the bench matches whichever build it is compiled with.
module tb_mv_pattern_bands;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timing_hs = 1'b0, timing_vs = 1'b0, timing_de = 1'b0;
    logic [11:0] timing_x = '0, timing_y = '0;
    logic mode = 1'b0, scroll_en = 1'b0;
    logic [7:0] scroll_step = '0;

    logic hs, vs, de;
    logic [7:0] rgb_r, rgb_g, rgb_b;
    logic hs2, vs2, de2;
    logic [7:0] rgb_r2, rgb_g2, rgb_b2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mv_pattern_bands dut (
        .clk(clk), .rst(rst),
        .timing_hs(timing_hs), .timing_vs(timing_vs), .timing_de(timing_de),
        .timing_x(timing_x), .timing_y(timing_y),
        .mode(mode), .scroll_en(scroll_en), .scroll_step(scroll_step),
        .hs(hs), .vs(vs), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
    );

    mv_pattern_bands #(.BAND_NUM(4), .BAND_SHIFT(5), .COLOR_W(8)) dut2 (
        .clk(clk), .rst(rst),
        .timing_hs(timing_hs), .timing_vs(timing_vs), .timing_de(timing_de),
        .timing_x(timing_x), .timing_y(timing_y),
        .mode(mode), .scroll_en(scroll_en), .scroll_step(scroll_step),
        .hs(hs2), .vs(vs2), .de(de2),
        .rgb_r(rgb_r2), .rgb_g(rgb_g2), .rgb_b(rgb_b2)
    );

    typedef struct {
        logic        md;
        logic        hs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] e1;
        logic [23:0] e2;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic frame(input logic m);
        mode = m;
        timing_vs = 1'b1;
        tick();
        timing_vs = 1'b0;
        tick();
        chk("vs_delay", {31'd0, vs}, 32'd1);
    endtask

    function automatic logic [23:0] colour(input logic [2:0] band, input logic [7:0] g);
        case (band)
            3'd0: return {8'hFF, g, g};
            3'd1: return {g, 8'hFF, g};
            3'd2: return {g, g, 8'hFF};
            3'd3: return {8'hFF, g, 8'hFF};
            3'd4: return {16'h0000, g};
            3'd5: return {16'hFFFF, g};
            3'd6: return {g, g, g};
            default: return 24'h000000;
        endcase
    endfunction

    initial begin
        logic [10:0] exp_off;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd0,    24'hFF0000, 24'hFF0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'd0,   12'd300,  24'h2CFF2C, 24'h60FF60};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd1900, 24'h000000, 24'hFF60FF};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd528,  24'h1010FF, 24'hFF8080};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'd0,   12'd1023, 24'hFFFFFF, 24'hFFF8FF};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd1029, 24'h000005, 24'hFF2828};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd1408, 24'hFFFF80, 24'hFF0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd1587, 24'h333333, 24'h98FF98};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd2047, 24'h000000, 24'hFFF8FF};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd2049, 24'hFF0101, 24'hFF0808};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd33,   24'hFF2121, 24'h08FF08};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 12'd0,   12'd128,  24'hFF8080, 24'hFF0000};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 12'd0,   12'd300,  24'h000000, 24'h000000};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 12'd260, 12'd300,  24'h04FF04, 24'hFF2020};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 12'd0,   12'd1900, 24'hFF0000, 24'hFF0000};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 12'd123, 12'd456,  24'h000000, 24'h000000};

        // Reset state
        #2 rst = 1'b1;
        tick();
        tick();
        chk("reset_outputs", {5'd0, hs, vs, de, rgb_r, rgb_g, rgb_b}, 32'd0);
        rst = 1'b0;
        tick();

        // Exact 2-clock latency, starting from blanked outputs
        timing_y = 12'd300; timing_de = 1'b1; timing_hs = 1'b1;
        tick();
        chk("lat_1clk", {6'd0, hs, de, rgb_r, rgb_g, rgb_b}, 32'd0);
        tick();
        chk("lat_2clk", {6'd0, hs, de, rgb_r, rgb_g, rgb_b}, {6'd0, 2'b11, 24'h2CFF2C});

        for (int i = 0; i < 16; i++) begin
            if (i == 0 || tbl[i].md != tbl[i-1].md)
                frame(tbl[i].md);
            timing_hs = tbl[i].hs;
            timing_de = tbl[i].de;
            timing_x  = tbl[i].x;
            timing_y  = tbl[i].y;
            tick();
            tick();
            chk($sformatf("rgb_row%0d", i), {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, tbl[i].e1});
            chk($sformatf("rgb2_row%0d", i), {8'd0, rgb_r2, rgb_g2, rgb_b2}, {8'd0, tbl[i].e2});
            chk($sformatf("tim_row%0d", i), {29'd0, hs, vs, de}, {29'd0, tbl[i].hs, 1'b0, tbl[i].de});
        end

        // Mid-frame mode change has no effect until the next vs rising edge
        frame(1'b0);
        timing_de = 1'b1; timing_hs = 1'b0; timing_x = 12'd260; timing_y = 12'd300;
        mode = 1'b1;
        tick();
        tick();
        chk("mode_midframe", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, 24'h2CFF2C});
        frame(1'b1);
        tick();
        tick();
        chk("mode_nextframe", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, 24'h04FF04});

        // Scrolling
        timing_x = 12'd0; timing_y = 12'd0; timing_de = 1'b1;
        scroll_en = 1'b1; scroll_step = 8'h40;
`ifdef MV_PATTERN_SCROLL_EN
        exp_off = '0;
        for (int k = 1; k <= 38; k++) begin
            frame(1'b0);
            exp_off = exp_off + 11'h040;
            tick();
            tick();
            if (k <= 33)
                chk($sformatf("scroll_f%0d", k), {8'd0, rgb_r, rgb_g, rgb_b},
                    {8'd0, colour(exp_off[10:8], exp_off[7:0])});
        end
`else
        exp_off = '0;
        for (int k = 1; k <= 3; k++)
            frame(1'b0);
        timing_y = 12'd300;
        tick();
        tick();
        chk("scroll_ignored", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, 24'h2CFF2C});
        timing_y = 12'd0;
`endif

        // Reset mid-line: outputs clear at once, then offset 0 and mode latched at next frame
        timing_hs = 1'b1; timing_de = 1'b1; timing_x = 12'd260;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_async", {5'd0, hs, vs, de, rgb_r, rgb_g, rgb_b}, 32'd0);
        tick();
        tick();
        chk("rst_held", {5'd0, hs, vs, de, rgb_r, rgb_g, rgb_b}, 32'd0);
        rst = 1'b0;
        timing_hs = 1'b0; mode = 1'b1;
        tick();
        tick();
        chk("rst_mode_cleared", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, 24'hFF0000});
        scroll_en = 1'b0;
        frame(1'b1);
        tick();
        tick();
        chk("rst_first_frame", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, 24'h04FF04});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
